// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer with an 11-entry round-key buffer.
// Define AES_KEY_SCHED_ZEROIZE_EN to make the zeroize input wipe all key state.
module aes_key_sched_ctrl #(
  parameter int NUM_RND = 10,
  parameter int KEY_W   = 128
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_i,
  input  logic             zeroize,
  output logic             busy,
  output logic             done,
  output logic             keys_valid,
  output logic             kg_en,
  output logic             kg_next_rnd,
  output logic [3:0]       kg_rnd_number,
  output logic [KEY_W-1:0] kg_key_o,
  input  logic [KEY_W-1:0] kg_key_i,
  input  logic [3:0]       rk_rd_addr,
  output logic [KEY_W-1:0] rk_rd_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GEN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [3:0] LAST_RND  = 4'(NUM_RND - 1);
  localparam logic [3:0] LAST_ADDR = 4'(NUM_RND);

  logic [1:0]       state_q, state_d;
  logic [3:0]       rnd_cnt_q, rnd_cnt_d;
  logic [3:0]       wr_addr_q, wr_addr_d;
  logic             wr_pend_q, wr_pend_d;
  logic             done_q, done_d;
  logic             kv_q, kv_d;
  logic             accept;
  logic [KEY_W-1:0] key_q, key_d;
  logic [KEY_W-1:0] rd_q;
  logic [KEY_W-1:0] rk_mem_q [NUM_RND+1];
  logic             zap;

`ifdef AES_KEY_SCHED_ZEROIZE_EN
  assign zap = zeroize;
`else
  logic unused_zeroize;
  assign zap            = 1'b0;
  assign unused_zeroize = zeroize;
`endif

  always_comb begin
    state_d   = state_q;
    rnd_cnt_d = rnd_cnt_q;
    wr_addr_d = wr_addr_q;
    wr_pend_d = 1'b0;
    done_d    = 1'b0;
    kv_d      = kv_q;
    key_d     = key_q;
    accept    = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (start) begin
          accept    = 1'b1;
          key_d     = key_i;
          rnd_cnt_d = '0;
          kv_d      = 1'b0;
          state_d   = S_GEN;
        end
      end
      (state_q == S_GEN): begin
        // Round key k+1 lands on kg_key_i one cycle after round k issues.
        wr_pend_d = 1'b1;
        wr_addr_d = rnd_cnt_q + 4'd1;
        rnd_cnt_d = rnd_cnt_q + 4'd1;
        if (rnd_cnt_q == LAST_RND) state_d = S_FLUSH;
      end
      (state_q == S_FLUSH): begin
        done_d  = 1'b1;
        kv_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q   <= S_IDLE;
      rnd_cnt_q <= '0;
      wr_addr_q <= '0;
      wr_pend_q <= 1'b0;
      done_q    <= 1'b0;
      kv_q      <= 1'b0;
      key_q     <= '0;
      for (int i = 0; i < NUM_RND + 1; i++) rk_mem_q[i] <= '0;
    end else if (zap) begin
      state_q   <= S_IDLE;
      rnd_cnt_q <= '0;
      wr_pend_q <= 1'b0;
      done_q    <= 1'b0;
      kv_q      <= 1'b0;
      key_q     <= '0;
      for (int i = 0; i < NUM_RND + 1; i++) rk_mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      rnd_cnt_q <= rnd_cnt_d;
      wr_addr_q <= wr_addr_d;
      wr_pend_q <= wr_pend_d;
      done_q    <= done_d;
      kv_q      <= kv_d;
      key_q     <= key_d;
      if (wr_pend_q) rk_mem_q[wr_addr_q] <= kg_key_i;
      if (accept) rk_mem_q[0] <= key_i;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      rd_q <= '0;
    end else if (rk_rd_addr <= LAST_ADDR) begin
      rd_q <= rk_mem_q[rk_rd_addr];
    end else begin
      rd_q <= '0;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign keys_valid    = kv_q;
  assign kg_en         = (state_q == S_GEN);
  assign kg_rnd_number = kg_en ? rnd_cnt_q : 4'd0;
  assign kg_next_rnd   = (kg_en && (rnd_cnt_q != 4'd0)) ||
                         (state_q == S_FLUSH);
  assign kg_key_o      = key_q;
  assign rk_rd_data    = rd_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: word-level FIPS-197 schedule model,
// per-cycle compare process and directed test-plan scenarios.
module tb_aes_key_sched_ctrl;

  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_SEQ  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K_JUNK = 128'hdeadbeef0123456789abcdeffedcba98;

  localparam logic [127:0] SBOX [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic         clk = 1'b0;
  logic         nrst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key_i = '0;
  logic         zeroize = 1'b0;
  logic         busy, done, keys_valid, kg_en, kg_next_rnd;
  logic [3:0]   kg_rnd_number;
  logic [127:0] kg_key_o;
  logic [127:0] kg_key_i;
  logic [3:0]   rk_rd_addr = '0;
  logic [127:0] rk_rd_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_done = 0;

  aes_key_sched_ctrl dut (
    .clk(clk), .nrst(nrst), .start(start), .key_i(key_i),
    .zeroize(zeroize), .busy(busy), .done(done),
    .keys_valid(keys_valid), .kg_en(kg_en),
    .kg_next_rnd(kg_next_rnd), .kg_rnd_number(kg_rnd_number),
    .kg_key_o(kg_key_o), .kg_key_i(kg_key_i),
    .rk_rd_addr(rk_rd_addr), .rk_rd_data(rk_rd_data)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sb(input logic [7:0] b);
    logic [127:0] row;
    row = SBOX[b[7:4]];
    return row[(15 - int'(b[3:0])) * 8 +: 8];
  endfunction

  function automatic logic [31:0] subrot(input logic [31:0] w);
    return {sb(w[23:16]), sb(w[15:8]), sb(w[7:0]), sb(w[31:24])};
  endfunction

  function automatic logic [7:0] rcon(input int r);
    logic [7:0] c;
    c = 8'h01;
    for (int i = 0; i < r; i++)
      c = c[7] ? ({c[6:0], 1'b0} ^ 8'h1b) : {c[6:0], 1'b0};
    return c;
  endfunction

  // One key-gen round, as the external datapath would compute it.
  function automatic logic [127:0] next_rk(input logic [127:0] k, input int r);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ subrot(k[31:0]) ^ {rcon(r), 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Reference: FIPS-197 word recurrence over the full 44-word schedule.
  function automatic logic [127:0] rk_of(input logic [127:0] key, input int n);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = subrot(t) ^ {rcon(i/4 - 1), 24'h0};
      w[i] = w[i-4] ^ t;
    end
    return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endfunction

  // Key-gen datapath stand-in: registered round output.
  logic [127:0] dp;
  always @(posedge clk) begin
    if (nrst) dp <= '0;
    else if (kg_en)
      dp <= next_rk(kg_next_rnd ? dp : kg_key_o, int'(kg_rnd_number));
  end
  assign kg_key_i = dp;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) n_done++;

  // Model: phase = cycles since accept (0 idle, 12 = done cycle, also idle).
  int           phase = 0;
  logic [127:0] m_key;
  logic [127:0] m_mem [11];
  logic [127:0] m_rd;
  logic         m_kv;
  logic         m_zap;

  always @(posedge clk) begin
    if (nrst) begin
      phase = 0;
      m_key = '0;
      for (int i = 0; i < 11; i++) m_mem[i] = '0;
      m_rd = '0;
      m_kv = 1'b0;
    end else begin
      m_rd = (rk_rd_addr <= 4'd10) ? m_mem[rk_rd_addr] : '0;
      m_zap = 1'b0;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
      m_zap = zeroize;
`endif
      if (m_zap) begin
        phase = 0;
        m_key = '0;
        for (int i = 0; i < 11; i++) m_mem[i] = '0;
        m_kv = 1'b0;
      end else begin
        if (phase >= 2 && phase <= 11) m_mem[phase-1] = rk_of(m_key, phase - 1);
        if ((phase == 0 || phase == 12) && start) begin
          m_key = key_i;
          m_mem[0] = key_i;
          m_kv = 1'b0;
          phase = 1;
        end else if (phase >= 1 && phase <= 11) begin
          phase++;
          if (phase == 12) m_kv = 1'b1;
        end else begin
          phase = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic e_busy, e_en;
    e_busy = (phase >= 1 && phase <= 11);
    e_en   = (phase >= 1 && phase <= 10);
    chk("cyc_busy", 128'(busy), 128'(e_busy));
    chk("cyc_done", 128'(done), 128'(phase == 12));
    chk("cyc_keys_valid", 128'(keys_valid), 128'(m_kv));
    chk("cyc_kg_en", 128'(kg_en), 128'(e_en));
    chk("cyc_rnd", 128'(kg_rnd_number), e_en ? 128'(phase - 1) : 128'(0));
    chk("cyc_rd_data", rk_rd_data, m_rd);
    if (e_busy) begin
      chk("cyc_next_rnd", 128'(kg_next_rnd), 128'(phase >= 2));
      chk("cyc_kg_key_o", kg_key_o, m_key);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_to(input int target);
    while (cyc < target) tick();
  endtask

  task automatic rd(input logic [3:0] a, input string nm, input logic [127:0] exp);
    rk_rd_addr = a;
    tick();
    chk(nm, rk_rd_data, exp);
  endtask

  task automatic pulse_start(input logic [127:0] k);
    key_i = k;
    start = 1'b1;
    tick();
    start = 1'b0;
    key_i = '0;
  endtask

  int t0, d0;

  initial begin
    chk("pin_rk1", rk_of(K_FIPS, 1), 128'ha0fafe1788542cb123a339392a6c7605);
    chk("pin_rk10", rk_of(K_FIPS, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("pin_seq_rk10", rk_of(K_SEQ, 10), 128'h13111d7fe3944a17f307a78b4d2b30c5);

    repeat (3) tick();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_kv", 128'(keys_valid), 128'(0));
    chk("rst_kg_key_o", kg_key_o, '0);
    nrst = 1'b0;
    tick();

    // FIPS expansion
    t0 = cyc; d0 = n_done;
    pulse_start(K_FIPS);
    run_to(t0 + 11);
    chk("fips_no_done_t11", 128'(done), 128'(0));
    tick();
    chk("fips_done_t12", 128'(done), 128'(1));
    tick();
    chk("fips_done_once", 128'(n_done - d0), 128'(1));
    rd(4'd0, "fips_rd0", K_FIPS);
    rd(4'd1, "fips_rd1", 128'ha0fafe1788542cb123a339392a6c7605);
    rd(4'd10, "fips_rd10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // start while busy is ignored
    t0 = cyc; d0 = n_done;
    pulse_start(K_FIPS);
    run_to(t0 + 5);
    pulse_start(K_JUNK);
    run_to(t0 + 12);
    chk("busy_start_done_t12", 128'(done), 128'(1));
    repeat (4) tick();
    chk("busy_start_done_once", 128'(n_done - d0), 128'(1));
    rd(4'd10, "busy_start_rd10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // back-to-back: start in the done cycle
    t0 = cyc;
    pulse_start(K_FIPS);
    run_to(t0 + 12);
    chk("b2b_done1", 128'(done), 128'(1));
    t0 = cyc;
    pulse_start(K_SEQ);
    chk("b2b_accepted", 128'(busy), 128'(1));
    run_to(t0 + 12);
    chk("b2b_done2", 128'(done), 128'(1));
    rd(4'd10, "b2b_rd10", 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("b2b_kv", 128'(keys_valid), 128'(1));

    // reset mid-GEN
    t0 = cyc;
    pulse_start(K_FIPS);
    run_to(t0 + 6);
    d0 = n_done;
    nrst = 1'b1;
    tick();
    nrst = 1'b0;
    chk("rst_mid_busy", 128'(busy), 128'(0));
    chk("rst_mid_en", 128'(kg_en), 128'(0));
    chk("rst_mid_kv", 128'(keys_valid), 128'(0));
    chk("rst_mid_key", kg_key_o, '0);
    chk("rst_mid_rd", rk_rd_data, '0);
    rd(4'd0, "rst_mid_rd0", '0);
    rd(4'd10, "rst_mid_rd10", '0);
    repeat (14) tick();
    chk("rst_mid_no_done", 128'(n_done - d0), 128'(0));

    // out-of-range read after a completed run
    t0 = cyc;
    pulse_start(K_FIPS);
    run_to(t0 + 13);
    rd(4'd10, "oor_pre_rd10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    rd(4'd13, "oor_rd13", '0);

    // zeroize after a completed run
    chk("zero_pre_kv", 128'(keys_valid), 128'(1));
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
`ifdef AES_KEY_SCHED_ZEROIZE_EN
    chk("zero_kv", 128'(keys_valid), 128'(0));
    rd(4'd0, "zero_rd0", '0);
    rd(4'd10, "zero_rd10", '0);
`else
    chk("zero_kv", 128'(keys_valid), 128'(1));
    rd(4'd0, "zero_rd0", K_FIPS);
    rd(4'd10, "zero_rd10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
`endif
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
